// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pll_reset_sequencer                                         |
// | Desc   : Qualifies PLL lock, sequences the system reset, pulses PLL  |
// |          reset on lock timeout and tracks lock losses in RUN.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 256,
    parameter int LOCK_TIMEOUT       = 500000,
    parameter int PLL_RST_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       clear_lost,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       pll_reset,
    output logic       lock_lost,
    output logic [7:0] loss_count
);

    localparam int c_MAX_A   = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int c_MAX_B   = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
    localparam int c_MAX_CYC = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_PLLRST_LAST  = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST    = c_CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 w_lock_s;
    logic                 w_loss;
    logic [7:0]           w_loss_inc;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s)                     w_state_nxt = ST_STABLE;
                else if (r_cnt == c_TIMEOUT_LAST) w_state_nxt = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (r_cnt == c_PLLRST_LAST)       w_state_nxt = ST_WAIT_LOCK;
            end
            ST_STABLE: begin
                if (!w_lock_s)                    w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == c_STABLE_LAST)  w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_lock_s)                    w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == c_HOLD_LAST)    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_lock_s)                    w_state_nxt = ST_WAIT_LOCK;
            end
            default:                              w_state_nxt = ST_WAIT_LOCK;
        endcase
    end

    // Counter restarts on every state change; it has no role in RUN so it parks there.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_state != ST_RUN) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
    end

    assign w_loss     = (r_state == ST_RUN) && !w_lock_s;
    assign w_loss_inc = (loss_count == 8'hFF) ? 8'hFF : loss_count + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            sys_rst_n <= 1'b0;
            pll_reset <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            sys_rst_n <= (w_state_nxt == ST_RUN);
            pll_reset <= (w_state_nxt == ST_PLL_RST);
        end
    end

    // A loss on the same edge as clear_lost takes priority and counts as the first loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost  <= 1'b0;
            loss_count <= 8'd0;
        end else if (w_loss) begin
            lock_lost  <= 1'b1;
            loss_count <= clear_lost ? 8'd1 : w_loss_inc;
        end else if (clear_lost) begin
            lock_lost  <= 1'b0;
            loss_count <= 8'd0;
        end
    end

    assign ready = sys_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_pll_reset_sequencer                                      |
// | Desc   : Self-checking bench for pll_reset_sequencer                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLD   = 3;
    localparam int TMO    = 20;
    localparam int PLLRST = 5;
    localparam int QUAL   = 1 + STABLE + HOLD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       clear_lost;
    logic       sys_rst_n;
    logic       ready;
    logic       pll_reset;
    logic       lock_lost;
    logic [7:0] loss_count;

    int n_cmp = 0;
    int n_err = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (STABLE),
        .RESET_HOLD_CYCLES  (HOLD),
        .LOCK_TIMEOUT       (TMO),
        .PLL_RST_CYCLES     (PLLRST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .clear_lost (clear_lost),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .pll_reset  (pll_reset),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock qualification as a run-length of consecutive synced-lock edges.
    int m_good = 0;
    int m_wait = 0;
    int m_prst = 0;
    int m_lost = 0;
    int m_cnt  = 0;
    int m_hist[$];

    task automatic model_reset();
        m_good = 0; m_wait = 0; m_prst = 0; m_lost = 0; m_cnt = 0;
        m_hist.delete();
    endtask

    task automatic model_step(input logic lk, input logic clr);
        int  ls;
        bit  loss;
        ls   = (m_hist.size() >= SYNC) ? m_hist[m_hist.size() - SYNC] : 0;
        m_hist.push_back(int'(lk));
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        loss = 1'b0;
        if (m_prst > 0) begin
            m_prst--;
        end else if (m_good > 0) begin
            if (ls != 0) begin
                if (m_good < QUAL) m_good++;
            end else begin
                loss   = (m_good >= QUAL);
                m_good = 0;
                m_wait = 0;
            end
        end else if (ls != 0) begin
            m_good = 1;
        end else if (m_wait == TMO - 1) begin
            m_prst = PLLRST;
            m_wait = 0;
        end else begin
            m_wait++;
        end
        if (loss) begin
            m_lost = 1;
            m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_lost = 0;
            m_cnt  = 0;
        end
    endtask

    always @(negedge rst_n) model_reset();
    always @(posedge clk) if (rst_n === 1'b1) model_step(pll_lock, clear_lost);

    always @(negedge clk) begin
        chk("sys_rst_n",  sys_rst_n,  m_good >= QUAL);
        chk("ready",      ready,      m_good >= QUAL);
        chk("pll_reset",  pll_reset,  m_prst > 0);
        chk("lock_lost",  lock_lost,  m_lost);
        chk("loss_count", loss_count, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pll_lock = 1'b0; clear_lost = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Edges (1 = next edge) until sys_rst_n reaches lvl; -1 if it never does.
    task automatic lat(input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (sys_rst_n === lvl) begin n = i; break; end
        end
        #2;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rise1, fall1, rise2;
        logic pr[1:60];
        logic sr_any;
        int len;

        rst_n = 1'b0; pll_lock = 1'b0; clear_lost = 1'b0;
        #1;
        chk("reset_sys_rst_n", sys_rst_n, 0);
        chk("reset_pll_reset", pll_reset, 0);
        do_reset();

        // 1: straight qualification
        pll_lock = 1'b1;
        lat(1'b1, n);
        chk("lat_first_lock", n, 10);

        // 2: loss in RUN, then relock
        pll_lock = 1'b0;
        lat(1'b0, n);
        chk("lat_loss", n, 3);
        chk("loss_lock_lost", lock_lost, 1);
        chk("loss_count_1", loss_count, 1);
        pll_lock = 1'b1;
        lat(1'b1, n);
        chk("lat_relock", n, 10);
        clear_lost = 1'b1; tick(); clear_lost = 1'b0;
        chk("clear_lock_lost", lock_lost, 0);
        chk("clear_count", loss_count, 0);

        // 3: glitch during STABLE restarts qualification
        do_reset();
        pll_lock = 1'b1; tick(); tick();
        pll_lock = 1'b0; tick();
        pll_lock = 1'b1;
        lat(1'b1, n);
        chk("lat_after_glitch", n, 10);
        chk("glitch_count", loss_count, 0);

        // 4: no lock -> periodic PLL reset pulses
        do_reset();
        sr_any = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            pr[i]  = pll_reset;
            sr_any = sr_any | sys_rst_n;
        end
        #2;
        rise1 = -1; fall1 = -1; rise2 = -1;
        for (int i = 1; i <= 60; i++) begin
            if (rise1 < 0 && pr[i]) rise1 = i;
            else if (rise1 > 0 && fall1 < 0 && !pr[i]) fall1 = i;
            else if (fall1 > 0 && rise2 < 0 && pr[i]) rise2 = i;
        end
        chk("pll_rst_first_rise", rise1, 20);
        chk("pll_rst_width", fall1 - rise1, 5);
        chk("pll_rst_gap", rise2 - fall1, 20);
        chk("pll_rst_no_sysrst", sr_any, 0);

        // 5: loss counter saturation and clear/loss collision
        do_reset();
        pll_lock = 1'b1;
        lat(1'b1, n);
        for (int k = 0; k < 256; k++) begin
            pll_lock = 1'b0; tick(); tick(); tick();
            pll_lock = 1'b1;
            lat(1'b1, n);
            if (n < 0) begin
                chk("sat_relock_timeout", n, 10);
                break;
            end
        end
        chk("sat_count", loss_count, 255);
        chk("sat_lock_lost", lock_lost, 1);
        pll_lock = 1'b0; tick(); tick();
        clear_lost = 1'b1; tick(); clear_lost = 1'b0;
        chk("collide_sys_rst_n", sys_rst_n, 0);
        chk("collide_lock_lost", lock_lost, 1);
        chk("collide_count", loss_count, 1);

        // 6: async reset in HOLD
        pll_lock = 1'b1;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("async_sys_rst_n", sys_rst_n, 0);
        chk("async_ready", ready, 0);
        chk("async_pll_reset", pll_reset, 0);
        chk("async_lock_lost", lock_lost, 0);
        chk("async_count", loss_count, 0);
        tick();
        rst_n = 1'b1;
        lat(1'b1, n);
        chk("lat_after_async", n, 10);

        // Random lock traffic, clears and occasional resets against the model
        for (int s = 0; s < 300; s++) begin
            pll_lock = ($urandom_range(0, 3) != 0);
            len = pll_lock ? $urandom_range(1, 25) : $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                clear_lost = ($urandom_range(0, 15) == 0);
                tick();
            end
            clear_lost = 1'b0;
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
